// File: rtl/coin_pkg.sv
// Shared definitions for the coin button conditioner: filter state encoding,
// default filter length and coin counter width.
package coin_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_FILT_DN = 2'd1;
    localparam logic [1:0] ST_DOWN    = 2'd2;
    localparam logic [1:0] ST_FILT_UP = 2'd3;

    typedef enum logic [1:0] {
        Idle   = ST_IDLE,
        FiltDn = ST_FILT_DN,
        Down   = ST_DOWN,
        FiltUp = ST_FILT_UP
    } coin_state_e;

    // 20 ms at 50 MHz, minus one.
    localparam int unsigned CNT_MAX_20MS = 999_999;
    localparam int unsigned COIN_CNT_W   = 8;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for asynchronous single-bit inputs; the reset
// value is selectable so idle-high buttons do not look pressed out of reset.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic din,
    output logic dout
);

    logic [1:0] ff_q;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            ff_q <= {2{RST_VAL}};
        end else begin
            ff_q <= {ff_q[0], din};
        end
    end

    assign dout = ff_q[1];

endmodule

// File: rtl/coin_key_filter.sv
// Coin button conditioner: synchronises and debounces the active-low key and
// emits one pi_money pulse per accepted press, plus a running coin count.
module coin_key_filter
    import coin_pkg::*;
#(
    parameter int unsigned CNT_MAX = CNT_MAX_20MS
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic                  key_in,
    output logic                  pi_money,
    output logic                  key_state,
    output logic [COIN_CNT_W-1:0] coin_cnt
);

    localparam int unsigned CntW = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
    localparam logic [CntW-1:0] CntMaxV = CntW'(CNT_MAX);

    logic                  key_sync;
    coin_state_e           state_q, state_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic                  accept;
    logic                  pi_money_q;
    logic                  key_state_q;
    logic [COIN_CNT_W-1:0] coin_cnt_q;

    sync_2ff #(
        .RST_VAL (1'b1)
    ) u_key_sync (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .din       (key_in),
        .dout      (key_sync)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        case (state_q)
            Idle: begin
                if (!key_sync) begin
                    state_d = FiltDn;
                    cnt_d   = '0;
                end
            end
            FiltDn: begin
                if (key_sync) begin
                    // Any release during filtering restarts from scratch.
                    state_d = Idle;
                    cnt_d   = '0;
                end else if (cnt_q == CntMaxV) begin
                    state_d = Down;
                    cnt_d   = '0;
                    accept  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            Down: begin
                if (key_sync) begin
                    state_d = FiltUp;
                    cnt_d   = '0;
                end
            end
            FiltUp: begin
                if (!key_sync) begin
                    state_d = Down;
                    cnt_d   = '0;
                end else if (cnt_q == CntMaxV) begin
                    state_d = Idle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = Idle;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= Idle;
            cnt_q       <= '0;
            pi_money_q  <= 1'b0;
            key_state_q <= 1'b0;
            coin_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pi_money_q  <= accept;
            key_state_q <= (state_d == Down) || (state_d == FiltUp);
            coin_cnt_q  <= coin_cnt_q + COIN_CNT_W'(accept);
        end
    end

    assign pi_money  = pi_money_q;
    assign key_state = key_state_q;
    assign coin_cnt  = coin_cnt_q;

endmodule

// File: tb/tb_coin_key_filter.sv
// Directed bench for coin_key_filter with a short filter (CNT_MAX=4): vector
// table for press/bounce/reset timing, then async-reset and counter-wrap runs.
module tb_coin_key_filter;

    logic       sys_clk;
    logic       sys_rst_n;
    logic       key_in;
    logic       pi_money;
    logic       key_state;
    logic [7:0] coin_cnt;

    int checks;
    int failures;

    typedef struct {
        logic       key;
        logic       rst_n;
        logic       exp_pm;
        logic       exp_ks;
        logic [7:0] exp_cc;
    } vec_t;

    vec_t vecs[$];

    coin_key_filter #(
        .CNT_MAX (4)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .key_in    (key_in),
        .pi_money  (pi_money),
        .key_state (key_state),
        .coin_cnt  (coin_cnt)
    );

    initial sys_clk = 1'b0;
    always #10 sys_clk = ~sys_clk;

    task automatic add(input logic k, input logic r, input logic p, input logic s,
                       input logic [7:0] c, input int n);
        vec_t v;
        v.key    = k;
        v.rst_n  = r;
        v.exp_pm = p;
        v.exp_ks = s;
        v.exp_cc = c;
        repeat (n) vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input logic [7:0] got,
                       input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s idx=%0d got=%0h exp=%0h", name, idx, got, exp);
        end
    endtask

    // Apply inputs just after an edge, then sample 1 ns after the next edge.
    task automatic step(input logic k, input logic r);
        key_in    = k;
        sys_rst_n = r;
        @(posedge sys_clk);
        #1;
    endtask

    initial begin
        int  pulses;
        logic prev_pm;
        logic double_pulse;

        checks    = 0;
        failures  = 0;
        key_in    = 1'b1;
        sys_rst_n = 1'b0;

        // Reset and idle
        add(1, 0, 0, 0, 0, 2);
        add(1, 1, 0, 0, 0, 2);
        // Clean press: pulse after the 8th low edge, then release filter
        add(0, 1, 0, 0, 0, 7);
        add(0, 1, 1, 1, 1, 1);
        add(0, 1, 0, 1, 1, 2);
        add(1, 1, 0, 1, 1, 7);
        add(1, 1, 0, 0, 1, 3);
        // Press bounce 0,0,1,0,0,1 then stable low
        add(0, 1, 0, 0, 1, 2);
        add(1, 1, 0, 0, 1, 1);
        add(0, 1, 0, 0, 1, 2);
        add(1, 1, 0, 0, 1, 1);
        add(0, 1, 0, 0, 1, 7);
        add(0, 1, 1, 1, 2, 1);
        add(0, 1, 0, 1, 2, 2);
        // Release bounce 1,0,1 then stable high
        add(1, 1, 0, 1, 2, 1);
        add(0, 1, 0, 1, 2, 1);
        add(1, 1, 0, 1, 2, 7);
        add(1, 1, 0, 0, 2, 3);
        // Reset while filtering with cnt=3, key held through reset
        add(0, 1, 0, 0, 2, 6);
        add(0, 0, 0, 0, 0, 2);
        add(0, 1, 0, 0, 0, 7);
        add(0, 1, 1, 1, 1, 1);
        add(0, 1, 0, 1, 1, 1);
        add(1, 1, 0, 1, 1, 7);
        add(1, 1, 0, 0, 1, 3);

        foreach (vecs[i]) begin
            step(vecs[i].key, vecs[i].rst_n);
            chk("pi_money", i, {7'd0, pi_money}, {7'd0, vecs[i].exp_pm});
            chk("key_state", i, {7'd0, key_state}, {7'd0, vecs[i].exp_ks});
            chk("coin_cnt", i, coin_cnt, vecs[i].exp_cc);
        end

        // Asynchronous reset mid-cycle while the key is accepted and held
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1);
        chk("held_ks", 0, {7'd0, key_state}, 8'd1);
        chk("held_cc", 0, coin_cnt, 8'd2);
        #5;
        sys_rst_n = 1'b0;
        #1;
        chk("async_rst_ks", 0, {7'd0, key_state}, 8'd0);
        chk("async_rst_cc", 0, coin_cnt, 8'd0);
        chk("async_rst_pm", 0, {7'd0, pi_money}, 8'd0);
        @(posedge sys_clk);
        #1;
        for (int i = 0; i < 7; i++) begin
            step(1'b0, 1'b1);
            chk("post_rst_no_pulse", i, {7'd0, pi_money}, 8'd0);
        end
        step(1'b0, 1'b1);
        chk("post_rst_pulse", 7, {7'd0, pi_money}, 8'd1);
        chk("post_rst_cc", 7, coin_cnt, 8'd1);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1);

        // 256 presses wrap the coin counter back to 0
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        pulses       = 0;
        prev_pm      = 1'b0;
        double_pulse = 1'b0;
        for (int p = 0; p < 256; p++) begin
            for (int i = 0; i < 20; i++) begin
                step((i < 10) ? 1'b0 : 1'b1, 1'b1);
                if (pi_money) pulses++;
                if (pi_money && prev_pm) double_pulse = 1'b1;
                prev_pm = pi_money;
            end
        end
        chk("wrap_pulses", 0, 8'(pulses), 8'(256));
        chk("wrap_pulse_count_hi", 0, 8'(pulses >> 8), 8'd1);
        chk("wrap_single_cycle", 0, {7'd0, double_pulse}, 8'd0);
        chk("wrap_cc", 0, coin_cnt, 8'd0);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1);
        chk("wrap_plus_one_cc", 0, coin_cnt, 8'd1);
        chk("wrap_plus_one_ks", 0, {7'd0, key_state}, 8'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/coin_key_filter.md
# coin_key_filter

Input conditioner for the vending-machine FSM (`simple_fsm`). Takes the raw, bouncing, active-low coin button, synchronises and debounces it, and emits exactly one single-cycle `pi_money` pulse per accepted press. Sits directly upstream of `simple_fsm`; its `pi_money` output drives `simple_fsm.pi_money` unmodified. Also keeps a running count of accepted coins for debug and LED display.

## Interface

Parameters:
- `CNT_MAX`, default 999_999: the stable-low/high filter length minus one, counted in sys_clk cycles. The default gives 20 ms at 50 MHz.

Ports:
- `sys_clk` in 1: system clock; all logic is on the rising edge.
- `sys_rst_n` in 1: reset, asynchronous, active-low.
- `key_in` in 1: raw button, active-low, asynchronous to sys_clk, bouncing.
- `pi_money` out 1: one-cycle high pulse per accepted press; feeds `simple_fsm`.
- `key_state` out 1: debounced level; 1 = pressed.
- `coin_cnt` out 8: number of accepted presses, modulo 256.

## Operation

- **Synchroniser.** `key_in` passes through two flops to give `key_sync`. Both flops reset to 1 (released). Nothing downstream uses `key_in` directly.
- **FSM states.** IDLE, FILT_DN, DOWN, FILT_UP. Reset state is IDLE.
  - IDLE: when `key_sync`==0, go to FILT_DN with `cnt`=0.
  - FILT_DN:
    - `key_sync`==1 → IDLE, `cnt`=0 (bounce rejected).
    - `key_sync`==0 and `cnt`<CNT_MAX → `cnt`+1.
    - `key_sync`==0 and `cnt`==CNT_MAX → DOWN, `cnt`=0, pulse `pi_money`.
  - DOWN: when `key_sync`==1, go to FILT_UP with `cnt`=0.
  - FILT_UP:
    - `key_sync`==0 → DOWN, `cnt`=0.
    - `key_sync`==1 and `cnt`==CNT_MAX → IDLE, `cnt`=0. No pulse on release.
    - Otherwise `cnt`+1.
- **Counter.** `cnt` is wide enough for CNT_MAX, i.e. $clog2(CNT_MAX+1) bits. It never exceeds CNT_MAX.
- **`key_state`.** Registered; 1 in DOWN and FILT_UP, 0 in IDLE and FILT_DN.
- **`pi_money`.** Registered; high for exactly one cycle, on the cycle following the FILT_DN→DOWN edge. A key held indefinitely produces exactly one pulse.
- **`coin_cnt`.** Increments by 1 on the same edge that sets `pi_money`. Wraps 255→0 with no flag.
- **Reset.** Reset asserted mid-operation, in any state or mid-count, immediately clears:
  - state → IDLE
  - `cnt` → 0
  - `pi_money` → 0
  - `key_state` → 0
  - `coin_cnt` → 0
  - sync flops → 1
  
  A press still held when reset releases must pass the full filter before it pulses.

## Timing

- **Reset values.** `pi_money`=0, `key_state`=0, `coin_cnt`=0.
- **Press latency.** If `key_in` is low before rising edge N and stays low, `key_sync` is first seen low at edge N+2. `pi_money` and `key_state` go high after edge N+2+CNT_MAX+1. `pi_money` drops one edge later.
- **Bounce restart.** Any high glitch on `key_sync` during FILT_DN restarts the full filter.
- **Minimum press-to-press spacing.** A second pulse needs at least 2·(CNT_MAX+1) cycles of stable release-then-press after the first.
- **Minimum glitch width.** A glitch narrower than one clock may be missed by the synchroniser. This is acceptable.

## Structure

- **Shared package `coin_pkg`:**
  - state encoding localparams for IDLE, FILT_DN, DOWN and FILT_UP (2-bit binary)
  - `CNT_MAX_20MS` = 999_999
  - `COIN_CNT_W` = 8
- **Sub-module `sync_2ff`:** generic two-flop synchroniser with a reset-value parameter, set to 1 here. It is reused for other buttons.
- **Everything else** (FSM, counter, outputs) lives in `coin_key_filter`.

## Test plan

All scenarios use CNT_MAX=4 and a 20 ns clock.

1. **Clean press.** `key_in` is driven low at edge 10 and held.
   - `pi_money`=1 only after edge 17.
   - `key_state`=1 from edge 17.
   - `coin_cnt`=1.
2. **Bounce.** `key_in` pattern 0,0,1,0,0,1 on successive cycles, then stable low.
   - No pulse during the bounce.
   - Exactly one pulse, 5 cycles after the last `key_sync` high.
   - `coin_cnt`=1.
3. **Release bounce.** Press accepted, then `key_in` toggles 1,0,1 during release, then stays high.
   - No extra `pi_money`.
   - `key_state` returns to 0 only after 5 stable high cycles.
4. **Wrap.** 256 clean press/release pairs.
   - 256 single-cycle pulses.
   - `coin_cnt` reads 0 at the end.
   - Then one more press → `coin_cnt`=1.
5. **Reset mid-filter.** `sys_rst_n` pulsed low while in FILT_DN with `cnt`=3 and `key_in` still low.
   - All outputs are 0 during reset.
   - After release, the pulse arrives only after the full 2+5 cycles.
6. **Downstream check.** Connect to `simple_fsm` and make three clean presses.
   - `po_cola` pulses once, aligned with `simple_fsm`'s spec.
